axis_m_pkt: RTL
===============

// Module: axis_m_pkt
// PURPOSE
//  Buffered, parametrised AXI-Stream master. Successor to the single-word send/finish master.
//  Accepts a stream of words on a valid/ready write port and stores them in an internal FIFO.
//  Drives them out as multi-beat packets on AXIS with a registered output stage.
//  tlast comes from the writer or from a programmable fixed packet length.
//  Sits between a local producer and any AXIS slave in the design.
// PARAMETERS
//  DATA_WIDTH  32  width of in_data/tdata, >=8, multiple of 8
//  DEPTH       8   FIFO entries, power of 2, >=2
//  PKT_LEN     0   0: tlast = in_last; N>0: every Nth accepted word is marked last, in_last ignored
// PORTS
//  aclk       in   1                  clock, all logic on rising edge
//  areset_n   in   1                  reset, asynchronous, active-low
//  in_data    in   DATA_WIDTH         write data
//  in_last    in   1                  write word ends packet (used only when PKT_LEN==0)
//  in_valid   in   1                  write request
//  in_ready   out  1                  write accepted when in_valid&in_ready; = !fifo_full
//  tdata      out  DATA_WIDTH         AXIS data, registered
//  tlast      out  1                  AXIS last, registered
//  tvalid     out  1                  AXIS valid, registered
//  tready     in   1                  AXIS ready from slave
//  finish     out  1                  1-cycle pulse after the tlast beat handshakes
//  level      out  $clog2(DEPTH+2)    words held = FIFO count + output register occupancy
// BEHAVIOUR
//  Reset (async, areset_n=0)
//   - tvalid=0, tdata=0, tlast=0, finish=0, level=0, in_ready=1.
//   - Pointers and the packet counter clear; contents are dropped, including mid-packet.
//  Storage
//   - FIFO holds DEPTH entries of {last,data}.
//   - Pointers carry an extra wrap bit: full = MSB differs and rest equal.
//   - Pointers wrap modulo DEPTH.
//  Write
//   - in_valid&in_ready at edge N stores the word.
//   - When full, in_ready=0 and no write is taken, even if a read occurs the same cycle.
//  Output stage
//   - Loads from the FIFO at an edge when the FIFO is non-empty and (tvalid==0 or tvalid&tready).
//   - On tvalid&tready with an empty FIFO: tvalid->0, tdata->0, tlast->0.
//   - While tvalid=1 and tready=0, tdata/tlast are held stable. tvalid never drops without a handshake.
//   - Latency: a word written at edge N into an empty block has tvalid=1 after edge N+1.
//     No combinational in->out path.
//   - Back-to-back: with tready held at 1 and a non-empty FIFO, one beat transfers per cycle.
//  Packet length (PKT_LEN>0)
//   - Counter of $clog2(PKT_LEN+1) bits increments per accepted write.
//   - Write number PKT_LEN is stored with last=1 and the counter returns to 0.
//   - PKT_LEN=1 marks every word last.
//  finish
//   - =1 for exactly the cycle after an edge where tvalid&tready&tlast. 0 otherwise.
//  level
//   - Updated each edge: +1 on write, -1 on output handshake, unchanged on both or neither.
//   - Range 0..DEPTH+1.
// CONFIGURATION
//  AXIS_M_PKT_TKEEP_EN defined:
//   - Adds in_keep (in) and tkeep (out), each DATA_WIDTH/8 bits.
//   - in_keep is stored per entry; tkeep follows tdata timing.
//   - tkeep resets to 0, clears to 0 with tdata, and is held stable under backpressure.
//  AXIS_M_PKT_TKEEP_EN undefined:
//   - Ports absent, no storage added. The slave treats all bytes as valid.
// TESTING
//  1 Reset
//    - Stimulus: assert areset_n=0 mid-packet with 3 words held.
//    - Response: tvalid/tlast/finish/level=0 immediately; in_ready=1; no stale word after release.
//  2 Single word
//    - Stimulus: write 0xA5A5_0001 with in_last=1, tready=1.
//    - Response: tvalid=1 one edge later with tlast=1; finish pulses 1 cycle after the handshake.
//  3 Full
//    - Stimulus: DEPTH=8, tready=0, write 12 words.
//    - Response: 9 accepted (8 FIFO + output reg), in_ready=0, level=9.
//    - Then tready=1: words 1..9 emerge in order, one per cycle.
//  4 Backpressure
//    - Stimulus: toggle tready 1,0,0,1 during a 4-word packet 0x10..0x13.
//    - Response: tdata held while tready=0; no duplicate or lost beat; tlast only on 0x13.
//  5 Auto last
//    - Stimulus: PKT_LEN=3, stream 7 words with in_last=0.
//    - Response: tlast on words 3 and 6; counter holds 1 after word 7.
//  6 Simultaneous events
//    - Stimulus: at level=1, write and handshake on the same edge.
//    - Response: level stays 1 and tvalid stays 1 with the new word.

Source files
------------

// File: rtl/axis_m_pkt.sv
// Buffered AXI-Stream packet master: valid/ready write port -> FIFO -> registered AXIS output.
// Optional tkeep lanes are enabled with `define AXIS_M_PKT_TKEEP_EN.
module axis_m_pkt #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int PKT_LEN    = 0
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
`ifdef AXIS_M_PKT_TKEEP_EN
    input  logic [DATA_WIDTH/8-1:0]       in_keep,
`endif
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         tdata,
`ifdef AXIS_M_PKT_TKEEP_EN
    output logic [DATA_WIDTH/8-1:0]       tkeep,
`endif
    output logic                          tlast,
    output logic                          tvalid,
    input  logic                          tready,
    output logic                          finish,
    output logic [$clog2(DEPTH+2)-1:0]    level
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int LEVEL_W = $clog2(DEPTH + 2);
`ifdef AXIS_M_PKT_TKEEP_EN
    localparam int KEEP_W  = DATA_WIDTH / 8;
    localparam int ENTRY_W = DATA_WIDTH + 1 + KEEP_W;
`else
    localparam int ENTRY_W = DATA_WIDTH + 1;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_p0;
    logic [PTR_W-1:0]   rd_ptr_p0;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [ENTRY_W-1:0] out_p1;
    logic               wr_last;
    logic               full;
    logic               empty;
    logic               wr_acc;
    logic               hs;
    logic               load;
    logic               bypass;
    logic               fifo_wr;

    assign full     = (wr_ptr_p0[AW] != rd_ptr_p0[AW]) &&
                      (wr_ptr_p0[AW-1:0] == rd_ptr_p0[AW-1:0]);
    assign empty    = (wr_ptr_p0 == rd_ptr_p0);
    assign in_ready = !full;
    assign wr_acc   = in_valid && in_ready;
    assign hs       = tvalid && tready;
    assign load     = !empty && (!tvalid || tready);
    // An empty FIFO during a handshake forwards the incoming word straight into the output register
    assign bypass   = hs && empty && wr_acc;
    assign fifo_wr  = wr_acc && !bypass;

    generate
        if (PKT_LEN == 0) begin : g_ext_last
            assign wr_last = in_last;
        end else begin : g_auto_last
            localparam int CNT_W = $clog2(PKT_LEN + 1);
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);
            logic [CNT_W-1:0] pkt_cnt;

            always_ff @(posedge aclk or negedge areset_n) begin
                if (!areset_n) begin
                    pkt_cnt <= '0;
                end else if (wr_acc) begin
                    pkt_cnt <= (pkt_cnt == LAST_CNT) ? '0 : pkt_cnt + CNT_W'(1);
                end
            end

            assign wr_last = (pkt_cnt == LAST_CNT);
        end
    endgenerate

`ifdef AXIS_M_PKT_TKEEP_EN
    assign wr_entry = {in_keep, wr_last, in_data};
`else
    assign wr_entry = {wr_last, in_data};
`endif
    assign rd_entry = mem[rd_ptr_p0[AW-1:0]];

    // Stage p0: FIFO storage and pointers
    always_ff @(posedge aclk) begin
        if (fifo_wr) begin
            mem[wr_ptr_p0[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
        end else begin
            if (fifo_wr) wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
            if (load)    rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
        end
    end

    // Stage p1: registered AXIS output
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            out_p1 <= '0;
            tvalid <= 1'b0;
        end else if (load || bypass) begin
            out_p1 <= load ? rd_entry : wr_entry;
            tvalid <= 1'b1;
        end else if (hs) begin
            out_p1 <= '0;
            tvalid <= 1'b0;
        end
    end

    assign tdata = out_p1[DATA_WIDTH-1:0];
    assign tlast = out_p1[DATA_WIDTH];
`ifdef AXIS_M_PKT_TKEEP_EN
    assign tkeep = out_p1[ENTRY_W-1 -: KEEP_W];
`endif

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            finish <= 1'b0;
            level  <= '0;
        end else begin
            finish <= hs && tlast;
            case ({wr_acc, hs})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule
